// File: rtl/cc_bus_pkg.sv
// Coherence bus controller types: bus FSM states and block address helper.
package cc_bus_pkg;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, LOAD, DONE} bus_state_t;

    function automatic logic [31:0] block_base(input logic [31:0] addr, input int words);
        return addr & ~(32'(words * WORD_BYTES) - 32'd1);
    endfunction
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the RAM handshake state.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: picks a core and reports the priority to install
// once that core's transaction has finished.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_prio,
    input  logic       i_en,
    output logic       o_grant,
    output logic       o_valid,
    output logic       o_prio_next
);
    always_comb begin
        o_valid     = i_en & (|i_req);
        o_grant     = (&i_req) ? i_prio : i_req[1];
        o_prio_next = ~o_grant;
    end
endmodule

// File: rtl/cc_bus_controller.sv
// Snoopy MSI bus controller for two dcaches sharing one RAM port.
// Optional CC_BUS_STATS_EN adds saturating C2C / RAM-read / invalidate counters.
module cc_bus_controller
    import cpu_types_pkg::*, cc_bus_pkg::*;
#(
    parameter int BLOCK_WORDS = 2,
    parameter int RESET_PRIO  = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       dREN,
    input  logic [1:0]       dWEN,
    input  logic [1:0][31:0] daddr,
    input  logic [1:0][31:0] dstore,
    input  logic [1:0]       cctrans,
    input  logic [1:0]       ccwrite,
    output logic [1:0]       dwait,
    output logic [1:0][31:0] dload,
    output logic [1:0]       ccwait,
    output logic [1:0]       ccinv,
    output logic [1:0][31:0] ccsnoopaddr,
    output logic             ramREN,
    output logic             ramWEN,
    output word_t            ramaddr,
    output word_t            ramstore,
    input  word_t            ramload,
    input  ramstate_t        ramstate
`ifdef CC_BUS_STATS_EN
    ,
    output logic [31:0]      stat_c2c,
    output logic [31:0]      stat_ramrd,
    output logic [31:0]      stat_inv
`endif
);
    localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    bus_state_t       r_state;
    logic             r_req;
    logic             r_prio;
    logic             r_prio_next;
    logic             r_inv;
    logic [CNT_W-1:0] r_cnt;
    word_t            r_snoop_addr;

    logic w_grant;
    logic w_valid;
    logic w_prio_next;
    logic w_snp;
    logic w_access;
    logic w_last;

    assign w_snp    = ~r_req;
    assign w_access = (ramstate == ACCESS);
    assign w_last   = (r_cnt == LAST_WORD);

    rr_arbiter2 u_arb (
        .i_req       (dWEN | cctrans),
        .i_prio      (r_prio),
        .i_en        (r_state == IDLE),
        .o_grant     (w_grant),
        .o_valid     (w_valid),
        .o_prio_next (w_prio_next)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_req        <= 1'b0;
            r_prio       <= (RESET_PRIO != 0);
            r_prio_next  <= (RESET_PRIO != 0);
            r_inv        <= 1'b0;
            r_cnt        <= '0;
            r_snoop_addr <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_req        <= w_grant;
                        r_prio_next  <= w_prio_next;
                        r_inv        <= ccwrite[w_grant];
                        r_cnt        <= '0;
                        r_snoop_addr <= block_base(daddr[w_grant], BLOCK_WORDS);
                        // A pending writeback is drained before any coherence request.
                        r_state      <= dWEN[w_grant] ? WB : SNOOP;
                    end
                end
                WB, C2C, LOAD: begin
                    if (w_access) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state <= IDLE;
                            r_prio  <= r_prio_next;
                        end
                    end
                end
                SNOOP: begin
                    if (cctrans[w_snp]) begin
                        if (ccwrite[w_snp]) begin
                            r_state <= C2C;
                        end else if (dREN[r_req]) begin
                            r_state <= LOAD;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_prio  <= r_prio_next;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ramstate gates completion combinationally so a word finishes in its ACCESS cycle.
    always_comb begin
        dwait       = 2'b11;
        dload       = '0;
        ccwait      = 2'b00;
        ccinv       = 2'b00;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        unique case (r_state)
            IDLE: ;
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[r_req];
                ramstore = dstore[r_req];
                if (w_access) dwait[r_req] = 1'b0;
            end
            SNOOP: begin
                ccwait[w_snp]      = 1'b1;
                ccinv[w_snp]       = r_inv;
                ccsnoopaddr[w_snp] = r_snoop_addr;
            end
            C2C: begin
                ccwait[w_snp] = 1'b1;
                ramWEN        = 1'b1;
                ramaddr       = daddr[w_snp];
                ramstore      = dstore[w_snp];
                dload[r_req]  = dstore[w_snp];
                if (w_access) dwait = 2'b00;
            end
            LOAD: begin
                ramREN       = 1'b1;
                ramaddr      = daddr[r_req];
                dload[r_req] = ramload;
                if (w_access) dwait[r_req] = 1'b0;
            end
            DONE: dwait[r_req] = 1'b0;
            default: ;
        endcase
    end

`ifdef CC_BUS_STATS_EN
    logic [31:0] r_stat_c2c;
    logic [31:0] r_stat_ramrd;
    logic [31:0] r_stat_inv;
    logic        w_blk_done;

    assign w_blk_done = w_access & w_last;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stat_c2c   <= '0;
            r_stat_ramrd <= '0;
            r_stat_inv   <= '0;
        end else begin
            if (r_state == C2C && w_blk_done && r_stat_c2c != '1) begin
                r_stat_c2c <= r_stat_c2c + 32'd1;
            end
            if (r_state == LOAD && w_blk_done && r_stat_ramrd != '1) begin
                r_stat_ramrd <= r_stat_ramrd + 32'd1;
            end
            // Counted once per snoop, on the cycle the snooper answers.
            if (r_state == SNOOP && cctrans[w_snp] && r_inv && r_stat_inv != '1) begin
                r_stat_inv <= r_stat_inv + 32'd1;
            end
        end
    end

    assign stat_c2c   = r_stat_c2c;
    assign stat_ramrd = r_stat_ramrd;
    assign stat_inv   = r_stat_inv;
`endif
endmodule

// File: doc/cc_bus_controller.md
Name: cc_bus_controller

Overview:
- Snoopy MSI coherence bus controller for a two-core system. Each core has one private dcache.
- Arbitrates dcache misses, upgrades and writebacks onto the single RAM port.
- Issues snoops (ccwait/ccinv/ccsnoopaddr) to the non-requesting dcache.
- Sequences cache-to-cache transfers: the snooper's dirty block is forwarded to the requester and written to RAM in the same cycle.
- Sits between the two dcache caches_if instances and the RAM model.

Parameters:
BLOCK_WORDS, 2, words per cache block; supported values are 2 or 4 (word offset = 4*i).
RESET_PRIO, 0, core index given priority after reset.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset; synchronous, active-high
dREN  in  2  per-core data read request (miss fill)
dWEN  in  2  per-core data write (writeback, or snoop data supply)
daddr  in  2x32  per-core word address
dstore  in  2x32  per-core write data
cctrans  in  2  per-core coherence transaction request / snoop response valid
ccwrite  in  2  requester: intent to modify (BusRdX/upgrade); snooper: has dirty copy, will supply
dwait  out  2  per-core stall; low = current word completed
dload  out  2x32  per-core read data
ccwait  out  2  per-core snoop in progress, cache must service snoop
ccinv  out  2  per-core invalidate the snooped block
ccsnoopaddr  out  2x32  per-core snoop address (block-aligned)
ramREN  out  1  RAM read
ramWEN  out  1  RAM write
ramaddr  out  32  RAM word address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE/BUSY/ACCESS/ERROR; ACCESS = word done this cycle

Behaviour:
- All state is registered on CLK. RST=1 at an edge, including mid-transaction, forces:
  - state IDLE, prio=RESET_PRIO, word counter 0;
  - outputs dwait=2'b11, dload=0, ccwait=0, ccinv=0, ccsnoopaddr=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
- Request from core c = dWEN[c] | cctrans[c], sampled only in IDLE. Granted core r is latched; snooper s = ~r.
- Arbitration:
  - one requester → that core;
  - both → core == prio;
  - prio flips to ~r on return to IDLE.
  - A grant takes 1 cycle (IDLE→next state).
- Class is decided at grant: dWEN[r] & ~cctrans[r] → WB; otherwise → SNOOP. If dWEN and cctrans are both high, WB goes first.
- WB: RAM write of daddr[r]/dstore[r].
  - When ramstate==ACCESS, dwait[r]=0 that cycle and the word counter increments.
  - After BLOCK_WORDS words → IDLE.
- SNOOP:
  - ccwait[s]=1, ccsnoopaddr[s]=latched block address of r, ccinv[s]=latched ccwrite[r]. dwait[r]=1.
  - Waits until cctrans[s]=1, then:
    - ccwrite[s]=1 → C2C;
    - else if dREN[r] → LOAD;
    - else (upgrade only) → DONE.
- C2C:
  - ccwait[s] stays high.
  - ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s], dload[r]=dstore[s].
  - On ACCESS, dwait[s]=0 and dwait[r]=0 in the same cycle.
  - BLOCK_WORDS words, then → IDLE.
- LOAD: ramREN=1, ramaddr=daddr[r], dload[r]=ramload. On ACCESS, dwait[r]=0. BLOCK_WORDS words, then → IDLE.
- DONE: dwait[r]=0 for one cycle (upgrade acknowledge) → IDLE.
- ccwait/ccinv are never asserted to the requester.
- A transaction is never preempted.
- Outside its active transfer cycles, dwait for each core is 1.
- ramstate ERROR is treated as BUSY (retry).
- The word counter uses clog2(BLOCK_WORDS) bits and wraps to 0 at the block end.

Optional Feature:
- CC_BUS_STATS_EN defined adds three 32-bit saturating outputs: stat_c2c, stat_ramrd, stat_inv.
  - stat_c2c increments per completed C2C block.
  - stat_ramrd increments per completed LOAD block.
  - stat_inv increments per SNOOP with ccinv=1.
  - All three clear on RST.
- CC_BUS_STATS_EN undefined: the ports and counters are absent.

Decomposition:
- cpu_types_pkg already provides word_t and ramstate_t.
- Add a package cc_bus_pkg with the bus_state_t enum {IDLE, WB, SNOOP, C2C, LOAD, DONE} and the WORD_BYTES=4 constant.
- One sub-module: rr_arbiter2. Inputs req[1:0], prio, en; outputs grant index and a valid flag. It holds the round-robin flip logic.

Test Plan:
- Core0 dREN+cctrans, addr 0x100, ccwrite=0; core1 answers cctrans=1, ccwrite=0; RAM returns 0xAAAA/0xBBBB → ccwait[1]=1, ccinv[1]=0, ccsnoopaddr[1]=0x100, then ramREN, dload[0]=0xAAAA then 0xBBBB, dwait[0] low once per word.
- Core1 miss 0x200, ccwrite=1; core0 snoop reply ccwrite=1, dstore 0x1111/0x2222 → ccinv[0]=1, ramWEN with ramstore=0x1111, dload[1]=0x1111 in the same cycle, both dwait low; repeated for word 2; no ramREN.
- Both cores request in the same cycle from reset (RESET_PRIO=0) → core0 served first, core1 next; a third simultaneous pair → core0 served again only after core1.
- Core0 dWEN writeback 0x300 data 0xDEAD/0xBEEF → two RAM writes, no ccwait on either core.
- Upgrade: core1 cctrans=1, ccwrite=1, dREN=0; snooper cctrans=1, ccwrite=0 → ccinv[0]=1, a single-cycle dwait[1]=0, no RAM activity.
- RST=1 asserted during C2C word 1 → next cycle all outputs at reset values, state IDLE; the following request completes normally.
